// File: rtl/ita_package.sv
// Shared ITA types: datapath step enum, sequencer state enum and sequencer constants.
package ita_package;

   typedef enum logic [3:0] {
      Idle, Q, K, V, QK, AV, OW, F1, F2
   } step_e;

   typedef enum logic [1:0] {
      SeqIdle, SeqIssue, SeqDrain
   } seq_state_e;

   localparam int unsigned StallCntWidth = 32;

endpackage

// File: rtl/ita_step_sequencer_next.sv
// Step successor function: from Idle yields the first step of the selected pass type,
// from the final step of a pass yields Idle with last_o set.
module ita_step_next
   import ita_package::*;
(
   input  step_e step_i,
   input  logic  mode_i,
   output step_e next_o,
   output logic  last_o
);

   always_comb begin
      next_o = Idle;
      last_o = 1'b0;
      case (step_i)
         Idle:    next_o = mode_i ? Q : F1;
         Q:       next_o = K;
         K:       next_o = V;
         V:       next_o = QK;
         QK:      next_o = AV;
         AV:      next_o = OW;
         OW:      last_o = 1'b1;
         F1:      next_o = F2;
         F2:      last_o = 1'b1;
         default: next_o = Idle;
      endcase
   end

endmodule

// File: rtl/ita_step_sequencer.sv
// Walks ITA through an attention or feedforward pass, issuing inner tiles per step.
// Optional handshake stall counter enabled by ITA_STEP_SEQ_STALL_CNT_EN.
module ita_step_sequencer
   import ita_package::*;
#(
   parameter int unsigned CntWidth = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     start_i,
   input  logic                     mode_i,
   input  logic [CntWidth-1:0]      tiles_i,
   input  logic                     flush_i,
   output logic                     tile_valid_o,
   input  logic                     tile_ready_i,
   output logic [CntWidth-1:0]      tile_idx_o,
   output logic                     first_tile_o,
   output logic                     last_tile_o,
   output step_e                    step_o,
   input  logic                     step_done_i,
   output logic                     busy_o,
   output logic                     done_o,
   output logic [StallCntWidth-1:0] stall_cnt_o
);

   seq_state_e          state_q, state_d;
   step_e               step_q, step_d, step_nxt;
   logic                mode_q, mode_d, mode_sel, step_is_last;
   logic [CntWidth-1:0] tiles_q, tiles_d, idx_q, idx_d;
   logic                done_q, done_d;
   logic                idx_at_last;

   // In Idle the successor of Idle is the first step, chosen by the live mode input.
   assign mode_sel = (state_q == SeqIdle) ? mode_i : mode_q;

   ita_step_next u_step_next (
      .step_i (step_q),
      .mode_i (mode_sel),
      .next_o (step_nxt),
      .last_o (step_is_last)
   );

   assign idx_at_last = (idx_q == tiles_q - CntWidth'(1));

   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      mode_d  = mode_q;
      tiles_d = tiles_q;
      idx_d   = idx_q;
      done_d  = 1'b0;
      if (flush_i) begin
         state_d = SeqIdle;
         step_d  = Idle;
         idx_d   = '0;
      end else begin
         case (state_q)
            SeqIdle: begin
               if (start_i) begin
                  state_d = SeqIssue;
                  mode_d  = mode_i;
                  tiles_d = (tiles_i == '0) ? CntWidth'(1) : tiles_i;
                  idx_d   = '0;
                  step_d  = step_nxt;
               end
            end
            SeqIssue: begin
               if (tile_ready_i) begin
                  if (idx_at_last) state_d = SeqDrain;
                  else             idx_d   = idx_q + CntWidth'(1);
               end
            end
            SeqDrain: begin
               if (step_done_i) begin
                  idx_d = '0;
                  if (step_is_last) begin
                     state_d = SeqIdle;
                     step_d  = Idle;
                     done_d  = 1'b1;
                  end else begin
                     state_d = SeqIssue;
                     step_d  = step_nxt;
                  end
               end
            end
            default: begin
               state_d = SeqIdle;
               step_d  = Idle;
               idx_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= SeqIdle;
         step_q  <= Idle;
         mode_q  <= 1'b0;
         tiles_q <= CntWidth'(1);
         idx_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         mode_q  <= mode_d;
         tiles_q <= tiles_d;
         idx_q   <= idx_d;
         done_q  <= done_d;
      end
   end

   assign tile_valid_o = (state_q == SeqIssue);
   assign tile_idx_o   = idx_q;
   assign first_tile_o = tile_valid_o && (idx_q == '0);
   assign last_tile_o  = tile_valid_o && idx_at_last;
   assign step_o       = step_q;
   assign busy_o       = (state_q != SeqIdle);
   assign done_o       = done_q;

`ifdef ITA_STEP_SEQ_STALL_CNT_EN
   logic [StallCntWidth-1:0] stall_q;
   logic                     stall_clr;

   assign stall_clr = (state_q == SeqIdle) && start_i && !flush_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)                              stall_q <= '0;
      else if (stall_clr)                     stall_q <= '0;
      else if (tile_valid_o && !tile_ready_i) stall_q <= stall_q + StallCntWidth'(1);
   end

   assign stall_cnt_o = stall_q;
`else
   assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_ita_step_sequencer.sv
// Scoreboarded bench for ita_step_sequencer: passes are expanded into expected tile streams.
module tb_ita_step_sequencer;
   import ita_package::*;

   localparam int CW = 8;

   logic          clk = 1'b0, rst_i = 1'b1;
   logic          start_i = 1'b0, mode_i = 1'b0, flush_i = 1'b0;
   logic          tile_ready_i = 1'b0, step_done_i = 1'b0;
   logic [CW-1:0] tiles_i = '0;
   logic          tile_valid_o, first_tile_o, last_tile_o, busy_o, done_o;
   logic [CW-1:0] tile_idx_o;
   step_e         step_o;
   logic [31:0]   stall_cnt_o;

   ita_step_sequencer #(.CntWidth(CW)) dut (
      .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .mode_i(mode_i), .tiles_i(tiles_i),
      .flush_i(flush_i), .tile_valid_o(tile_valid_o), .tile_ready_i(tile_ready_i),
      .tile_idx_o(tile_idx_o), .first_tile_o(first_tile_o), .last_tile_o(last_tile_o),
      .step_o(step_o), .step_done_i(step_done_i), .busy_o(busy_o), .done_o(done_o),
      .stall_cnt_o(stall_cnt_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      step_e st;
      int    idx;
      bit    first;
      bit    last;
   } tile_t;

   tile_t exp_q[$];
   tile_t mon_e;
   int    n_cmp = 0, n_err = 0;
   int    exp_done = 0, done_seen = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: every accepted tile must match the head of the expected stream.
   always @(negedge clk) begin
      if (tile_valid_o === 1'b1 && tile_ready_i === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_tile: got step %0d idx %0d expected none", step_o, tile_idx_o);
         end else begin
            mon_e = exp_q.pop_front();
            chk("tile_step", step_o, mon_e.st);
            chk("tile_idx", tile_idx_o, mon_e.idx);
            chk("tile_first", first_tile_o, mon_e.first);
            chk("tile_last", last_tile_o, mon_e.last);
         end
      end
      if (done_o === 1'b1) done_seen++;
   end

   task automatic run_pass(input bit m, input int t, input int rdy_pct, input bit same_cyc,
                           input bit start_busy, input step_e abort_st, input bit abort_rst,
                           input int stall_tile);
      step_e seq[$];
      int    tn, stalls, bound, stall_left, dly, exp_stall;
      bit    stalled;
      tn = (t == 0) ? 1 : t;
      if (m) seq = '{Q, K, V, QK, AV, OW};
      else   seq = '{F1, F2};
      foreach (seq[s])
         for (int i = 0; i < tn; i++) exp_q.push_back('{seq[s], i, i == 0, i == tn - 1});
      stalls = 0;
      @(posedge clk); #1;
      start_i = 1'b1; mode_i = m; tiles_i = t[CW-1:0]; tile_ready_i = 1'b0;
      @(posedge clk); #1;
      start_i = 1'b0;
      chk("start_busy", busy_o, 1);
      chk("start_step", step_o, seq[0]);
      chk("start_valid", tile_valid_o, 1);
      chk("start_first", first_tile_o, 1);
      for (int s = 0; s < seq.size(); s++) begin
         stall_left = 4;
         if (seq[s] == abort_st) begin
            tile_ready_i = 1'b0;
            if (abort_rst) begin
               rst_i = 1'b1;
               #1;
               chk("rst_busy", busy_o, 0);
               chk("rst_step", step_o, Idle);
               chk("rst_valid", tile_valid_o, 0);
               @(posedge clk); #1;
               rst_i = 1'b0;
            end else begin
               flush_i = 1'b1;
               @(posedge clk); #1;
               flush_i = 1'b0;
               chk("flush_busy", busy_o, 0);
               chk("flush_step", step_o, Idle);
               chk("flush_valid", tile_valid_o, 0);
               chk("flush_idx", tile_idx_o, 0);
            end
            chk("abort_done", done_o, 0);
            exp_q.delete();
            return;
         end
         bound = 0;
         forever begin
            stalled = 1'b0;
            if (s == 0 && stall_tile >= 0 && tile_idx_o == stall_tile[CW-1:0] && stall_left > 0) begin
               tile_ready_i = 1'b0;
               stall_left--;
               stalled = 1'b1;
            end else begin
               tile_ready_i = ($urandom_range(99) < rdy_pct);
            end
            if (!tile_ready_i) stalls++;
            if (start_busy) begin
               start_i = $urandom_range(1);
               mode_i  = ~m;
            end
            @(negedge clk);
            if (stalled) begin
               chk("stall_valid", tile_valid_o, 1);
               chk("stall_idx", tile_idx_o, stall_tile);
            end
            if (tile_valid_o && tile_ready_i && last_tile_o) begin
               if (same_cyc) step_done_i = 1'b1;
               @(posedge clk); #1;
               step_done_i = 1'b0; tile_ready_i = 1'b0; start_i = 1'b0;
               break;
            end
            if (++bound > 2000) begin
               n_cmp++; n_err++;
               $display("FAIL last_tile_timeout: got no last tile expected step %0d", seq[s]);
               start_i = 1'b0;
               return;
            end
            @(posedge clk); #1;
         end
         dly = same_cyc ? 3 : 2;
         for (int d = 0; d < dly; d++) begin
            chk("drain_valid", tile_valid_o, 0);
            chk("drain_busy", busy_o, 1);
            chk("drain_step", step_o, seq[s]);
            @(posedge clk); #1;
         end
         step_done_i = 1'b1;
         @(posedge clk); #1;
         step_done_i = 1'b0;
         if (s == seq.size() - 1) begin
            exp_done++;
            chk("end_done", done_o, 1);
            chk("end_busy", busy_o, 0);
            chk("end_step", step_o, Idle);
`ifdef ITA_STEP_SEQ_STALL_CNT_EN
            exp_stall = stalls;
`else
            exp_stall = 0;
`endif
            chk("stall_cnt", stall_cnt_o, exp_stall);
            @(posedge clk); #1;
            chk("done_width", done_o, 0);
         end else begin
            chk("next_step", step_o, seq[s + 1]);
            chk("next_valid", tile_valid_o, 1);
            chk("next_first", first_tile_o, 1);
         end
      end
   endtask

   initial begin
      #1;
      chk("rst_tile_valid", tile_valid_o, 0);
      chk("rst_tile_idx", tile_idx_o, 0);
      chk("rst_first", first_tile_o, 0);
      chk("rst_last", last_tile_o, 0);
      chk("rst_step_o", step_o, Idle);
      chk("rst_busy_o", busy_o, 0);
      chk("rst_done_o", done_o, 0);
      chk("rst_stall", stall_cnt_o, 0);
      #12 rst_i = 1'b0;
      run_pass(1, 3, 100, 0, 0, Idle, 0, -1);
      run_pass(0, 0, 100, 0, 0, Idle, 0, -1);
      run_pass(0, 3, 100, 0, 0, Idle, 0, 1);
      run_pass(0, 2, 100, 1, 0, Idle, 0, -1);
      run_pass(1, 2, 100, 0, 0, AV, 0, -1);
      run_pass(0, 2, 100, 0, 0, Idle, 0, -1);
      run_pass(1, 2, 100, 0, 0, K, 1, -1);
      run_pass(1, 1, 100, 0, 0, Idle, 0, -1);
      run_pass(1, 2, 70, 0, 1, Idle, 0, -1);
      for (int r = 0; r < 6; r++)
         run_pass($urandom_range(1), $urandom_range(5), $urandom_range(100, 50),
                  $urandom_range(1), $urandom_range(1), Idle, 0, -1);
      repeat (3) @(posedge clk);
      #1;
      chk("done_count", done_seen, exp_done);
      chk("exp_q_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/ita_step_sequencer.md
# ita_step_sequencer

Sequences ITA through one attention pass (Q, K, V, QK, AV, OW) or one feedforward pass (F1, F2). For each step it issues inner tiles to the datapath under a valid/ready handshake, with first/last-tile flags. It then waits for the datapath to report that the step has drained before it advances. It sits between the host configuration interface and the ITA datapath, and provides the step, tile-flag and busy signals used there.

## Interface
- CntWidth, default 8: width of the tile count and tile index.
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset; asynchronous, active-high.
- start_i  in  1  start a pass; sampled only in Idle.
- mode_i  in  1  pass type: 1 = attention, 0 = feedforward; latched at start.
- tiles_i  in  CntWidth  inner tiles per step; latched at start; value 0 is treated as 1.
- flush_i  in  1  synchronous abort back to Idle.
- tile_valid_o  out  1  a tile is offered to the datapath.
- tile_ready_i  in  1  datapath accepts the offered tile.
- tile_idx_o  out  CntWidth  index of the offered tile, 0..tiles-1.
- first_tile_o  out  1  high when tile_idx_o == 0.
- last_tile_o  out  1  high when tile_idx_o == tiles-1.
- step_o  out  step_e  current step; Idle when not busy.
- step_done_i  in  1  datapath has drained the current step.
- busy_o  out  1  high in any state other than Idle.
- done_o  out  1  one-cycle pulse when a pass completes.
- stall_cnt_o  out  32  count of handshake stall cycles (see Configuration).

## Operation
- State machine states:
  - Idle.
  - Issue: offering tiles.
  - Drain: waiting for step_done_i.
- Step order:
  - Attention: Q, K, V, QK, AV, OW.
  - Feedforward: F1, F2.
  - The step register holds the current step; a next-step function gives its successor, and the successor of the last step is Idle.
- Idle to Issue: on start_i. This latches mode_i and max(tiles_i, 1), clears tile_idx, and loads the first step.
- Issue: tile_valid_o is held at 1. On tile_valid_o && tile_ready_i:
  - if tile_idx == tiles-1, go to Drain;
  - otherwise, increment tile_idx.
- Drain: tile_valid_o = 0. On step_done_i:
  - if the step is not the last, clear tile_idx, load the next step and go to Issue;
  - if the step is the last, go to Idle and assert done_o for one cycle.
- step_done_i is ignored in Idle and Issue. That includes the cycle in which the last tile is accepted.
- start_i while busy is ignored; it is not queued.
- flush_i has priority over every other input:
  - the next state is Idle, tile_idx is cleared and step_o is Idle;
  - done_o is not asserted.
- Only the stall counter wraps. No other counter can overflow, because tile_idx never exceeds tiles-1.

## Timing
- Reset values:
  - tile_valid_o = 0, tile_idx_o = 0, first_tile_o = 0, last_tile_o = 0;
  - step_o = Idle, busy_o = 0, done_o = 0, stall_cnt_o = 0.
- All outputs are driven from registers, or decoded combinationally from state and tile_idx only. No input-to-output combinational paths.
- start_i sampled at edge T: at T+1, busy_o = 1, step_o = the first step, tile_valid_o = 1 and first_tile_o = 1.
- With tile_ready_i held at 1, one tile is issued per cycle. A step of N tiles occupies N cycles in Issue, followed by at least 1 cycle in Drain.
- step_done_i sampled in Drain at edge T: the next step is offered from T+1.
- For the last step, done_o = 1 and busy_o = 0 at T+1. A new start_i is accepted from T+1.
- first_tile_o and last_tile_o are both high for tiles = 1. Both are gated by tile_valid_o.
- tile_valid_o, once asserted, stays high until accepted (AXI-style) unless flush_i or reset occurs.
- Reset mid-pass: state returns to Idle immediately (asynchronous). No done_o.

## Configuration
- ITA_STEP_SEQ_STALL_CNT_EN defined:
  - a 32-bit counter increments every cycle in which tile_valid_o && !tile_ready_i;
  - it clears on start acceptance and on reset;
  - it wraps from 2^32-1 to 0;
  - it holds its value in Idle.
- ITA_STEP_SEQ_STALL_CNT_EN undefined: no counter is instantiated, and stall_cnt_o is tied to 0.

## Structure
- ita_package holds:
  - step_e, which is reused rather than redefined;
  - the new state enum seq_state_e {SeqIdle, SeqIssue, SeqDrain};
  - the constant StallCntWidth = 32.
- Sub-module ita_step_next: a combinational successor function taking (step, mode) and returning (next step, is-last flag).
- All registers live in ita_step_sequencer.

## Test plan
- Attention pass with tiles = 3, ready always 1, step_done_i pulsed 2 cycles after each last tile:
  - step_o sequence is Q, K, V, QK, AV, OW;
  - 18 accepted tiles in total;
  - tile_idx_o 0,1,2 within each step;
  - one done_o pulse, then busy_o = 0.
- Feedforward pass with tiles_i = 0:
  - one tile each for F1 and F2, with first_tile_o = last_tile_o = 1;
  - done_o after the second step_done_i.
- tile_ready_i low for 4 cycles on tile 1:
  - tile_valid_o and tile_idx_o = 1 stay stable;
  - with the macro defined, stall_cnt_o = 4; without it, stall_cnt_o = 0.
- step_done_i in the same cycle as the last-tile handshake:
  - it is ignored and the sequencer stays in Drain;
  - a later step_done_i advances the step.
- flush_i during AV, and separately rst_i during K:
  - state goes to Idle, with busy_o = 0 and no done_o;
  - a new start_i is then accepted normally.
- start_i asserted while busy:
  - the current pass is unaffected;
  - exactly one done_o pulse is produced.
